// File: rtl/fetch_npc_unit_pkg.sv
// Shared branch-class encoding and reset PC for the fetch / next-PC slice.
// Imported by the interface, npc_gen and the fetch_npc_unit top.
package fetch_npc_unit_pkg;

  typedef logic [3:0] br_type_t;

  localparam br_type_t BR_NONE    = 4'd0;
  localparam br_type_t BR_BEQ     = 4'd1;
  localparam br_type_t BR_BNE     = 4'd2;
  localparam br_type_t BR_BGEZ    = 4'd3;
  localparam br_type_t BR_BGTZ    = 4'd4;
  localparam br_type_t BR_BLEZ    = 4'd5;
  localparam br_type_t BR_BLTZ    = 4'd6;
  localparam br_type_t BR_J       = 4'd7;
  localparam br_type_t BR_JR      = 4'd8;
  localparam br_type_t BR_BGEZALR = 4'd9;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/fetch_npc_unit_if.sv
// Fetch-side bundle: IM address/data, F/D outputs and decode-stage branch inputs.
// master = fetch_npc_unit, slave = surrounding pipeline (decoder, comparator, hazard unit, IM).
interface fetch_npc_unit_if;
  import fetch_npc_unit_pkg::*;

  logic        stall;
  logic [31:0] F_instr;
  logic [31:0] F_pc;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic [31:0] D_pc8;
  br_type_t    D_br_type;
  logic        D_equal;
  logic        D_equal_0;
  logic        D_great_0;
  logic [31:0] D_rs_val;
  logic [31:0] D_rt_val;
  logic        D_br_taken;

  modport master (
    input  stall, F_instr, D_br_type, D_equal, D_equal_0, D_great_0, D_rs_val, D_rt_val,
    output F_pc, D_instr, D_pc, D_pc8, D_br_taken
  );

  modport slave (
    output stall, F_instr, D_br_type, D_equal, D_equal_0, D_great_0, D_rs_val, D_rt_val,
    input  F_pc, D_instr, D_pc, D_pc8, D_br_taken
  );

endinterface

// File: rtl/fetch_npc_unit_npc_gen.sv
// Combinational next-PC: resolves the D-stage branch/jump and picks target or F_pc+4.
// Zero latency; no flow control of its own (stall gating lives in the register stage).
module npc_gen
  import fetch_npc_unit_pkg::*;
(
  input  logic [31:0] F_pc,
  input  logic [31:0] D_pc,
  input  logic [31:0] D_instr,
  input  br_type_t    D_br_type,
  input  logic        D_equal,
  input  logic        D_equal_0,
  input  logic        D_great_0,
  input  logic [31:0] D_rs_val,
  input  logic [31:0] D_rt_val,
  output logic [31:0] npc,
  output logic        br_taken
);

  logic [31:0] br_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] target;
  logic        ge_0;
  logic        unused_opcode;

  assign br_off = {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
  assign br_tgt = D_pc + 32'd4 + br_off;
  assign j_tgt  = {D_pc[31:28], D_instr[25:0], 2'b00};
  assign ge_0   = D_great_0 | D_equal_0;
  // Opcode field is decoded upstream into D_br_type.
  assign unused_opcode = ^D_instr[31:26];

  always_comb begin
    br_taken = 1'b0;
    target   = br_tgt;
    case (D_br_type)
      BR_BEQ:     br_taken = D_equal;
      BR_BNE:     br_taken = !D_equal;
      BR_BGEZ:    br_taken = ge_0;
      BR_BGTZ:    br_taken = D_great_0;
      BR_BLEZ:    br_taken = !D_great_0;
      BR_BLTZ:    br_taken = !ge_0;
      BR_J: begin
        br_taken = 1'b1;
        target   = j_tgt;
      end
      BR_JR: begin
        br_taken = 1'b1;
        target   = D_rs_val;
      end
      BR_BGEZALR: begin
        br_taken = ge_0;
        target   = D_rt_val;
      end
      default:    br_taken = 1'b0;
    endcase
    npc = br_taken ? target : (F_pc + 32'd4);
  end

endmodule

// File: rtl/fetch_npc_unit.sv
// PC register and F/D pipeline register; redirect lands one unstalled edge after a taken D branch.
// stall=1 freezes PC and F/D completely; no bubbles are inserted here.
module fetch_npc_unit
  import fetch_npc_unit_pkg::*;
#(
  parameter logic [31:0] PC_RESET = RESET_PC
)(
  input  logic             clk,
  input  logic             reset,
  fetch_npc_unit_if.master bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [31:0] npc;
  logic        br_taken;

  npc_gen u_npc_gen (
    .F_pc      (pc_q),
    .D_pc      (d_pc_q),
    .D_instr   (d_instr_q),
    .D_br_type (bus.D_br_type),
    .D_equal   (bus.D_equal),
    .D_equal_0 (bus.D_equal_0),
    .D_great_0 (bus.D_great_0),
    .D_rs_val  (bus.D_rs_val),
    .D_rt_val  (bus.D_rt_val),
    .npc       (npc),
    .br_taken  (br_taken)
  );

  always_comb begin
    pc_d      = pc_q;
    d_instr_d = d_instr_q;
    d_pc_d    = d_pc_q;
    if (!bus.stall) begin
      pc_d      = npc;
      d_instr_d = bus.F_instr;
      d_pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      d_instr_q <= 32'd0;
      d_pc_q    <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      d_instr_q <= d_instr_d;
      d_pc_q    <= d_pc_d;
    end
  end

  assign bus.F_pc       = pc_q;
  assign bus.D_instr    = d_instr_q;
  assign bus.D_pc       = d_pc_q;
  assign bus.D_pc8      = d_pc_q + 32'd8;
  assign bus.D_br_taken = br_taken;

endmodule

// File: tb/tb_fetch_npc_unit.sv
// Randomized bench for fetch_npc_unit: a value-level reference model predicts each cycle's outputs
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_fetch_npc_unit;
  import fetch_npc_unit_pkg::*;

  logic clk;
  logic reset;

  fetch_npc_unit_if bus ();

  fetch_npc_unit #(.PC_RESET(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f_pc;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [31:0] d_pc8;
    logic        taken;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference state: what PC / F/D should hold right now.
  logic [31:0] m_pc    = 32'h0000_3000;
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_dpc   = 32'd0;

  function automatic logic ref_taken(input logic [3:0] bt, input logic [31:0] rs, input logic [31:0] rt);
    int srs;
    srs = int'($signed(rs));
    case (bt)
      4'd1:    return rs == rt;
      4'd2:    return rs != rt;
      4'd3:    return srs >= 0;
      4'd4:    return srs > 0;
      4'd5:    return srs <= 0;
      4'd6:    return srs < 0;
      4'd7:    return 1'b1;
      4'd8:    return 1'b1;
      4'd9:    return srs >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] bt, input logic [31:0] dpc,
                                             input logic [31:0] di, input logic [31:0] rs,
                                             input logic [31:0] rt);
    int off;
    logic [15:0] imm;
    imm = di[15:0];
    off = int'($signed(imm)) * 4;
    case (bt)
      4'd7:    return (dpc & 32'hF000_0000) + ({6'd0, di[25:0]} * 32'd4);
      4'd8:    return rs;
      4'd9:    return rt;
      default: return dpc + 32'd4 + 32'(off);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs, predict this cycle's outputs, advance the model across the edge.
  task automatic drive(input logic rst, input logic stl, input logic [31:0] fi,
                       input logic [3:0] bt, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic tk;
    logic [31:0] tgt;
    reset         = rst;
    bus.stall     = stl;
    bus.F_instr   = fi;
    bus.D_br_type = bt;
    bus.D_rs_val  = rs;
    bus.D_rt_val  = rt;
    bus.D_equal   = (rs == rt);
    bus.D_equal_0 = (rs == 32'd0);
    bus.D_great_0 = ($signed(rs) > 0);
    tk  = ref_taken(bt, rs, rt);
    tgt = ref_target(bt, m_dpc, m_instr, rs, rt);
    e.f_pc    = m_pc;
    e.d_instr = m_instr;
    e.d_pc    = m_dpc;
    e.d_pc8   = m_dpc + 32'd8;
    e.taken   = tk;
    exp_q.push_back(e);
    if (rst) begin
      m_pc    = 32'h0000_3000;
      m_instr = 32'd0;
      m_dpc   = 32'd0;
    end else if (!stl) begin
      m_dpc   = m_pc;
      m_instr = fi;
      m_pc    = tk ? tgt : m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("F_pc",       bus.F_pc,    e.f_pc);
      check("D_instr",    bus.D_instr, e.d_instr);
      check("D_pc",       bus.D_pc,    e.d_pc);
      check("D_pc8",      bus.D_pc8,   e.d_pc8);
      check("D_br_taken", {31'd0, bus.D_br_taken}, {31'd0, e.taken});
    end
  end

  initial begin
    logic [31:0] rs, rt;
    reset         = 1'b1;
    bus.stall     = 1'b0;
    bus.F_instr   = 32'd0;
    bus.D_br_type = BR_NONE;
    bus.D_rs_val  = 32'd0;
    bus.D_rt_val  = 32'd0;
    bus.D_equal   = 1'b0;
    bus.D_equal_0 = 1'b0;
    bus.D_great_0 = 1'b0;
    @(posedge clk);
    #1;

    // Reset and sequential fetch.
    drive(1, 0, 32'h1111_1111, BR_NONE, 0, 0);
    drive(1, 0, 32'h2222_2222, BR_NONE, 0, 0);
    drive(0, 0, 32'hA000_0000, BR_NONE, 0, 0);   // F_pc 3000
    drive(0, 0, 32'hA000_0004, BR_NONE, 0, 0);   // F_pc 3004
    drive(0, 0, 32'h1000_FFFE, BR_NONE, 0, 0);   // beq at 3008
    drive(0, 0, 32'hA000_000C, BR_BEQ, 7, 7);    // taken -> 3004
    drive(0, 0, 32'h1000_FFFE, BR_NONE, 0, 0);   // F_pc 3004, beq re-fetched
    drive(0, 0, 32'hA000_0008, BR_BEQ, 7, 9);    // not taken
    // Zero-compare family with rs=0 then rs=-5.
    drive(0, 0, 32'h0400_0010, BR_BGEZ, 0, 3);
    drive(0, 0, 32'h0400_0020, BR_BLEZ, 0, 3);
    drive(0, 0, 32'h0400_0030, BR_BGTZ, 0, 3);
    drive(0, 0, 32'h0400_0040, BR_BLTZ, 0, 3);
    drive(0, 0, 32'h0400_0050, BR_BGEZ, 32'hFFFF_FFFB, 3);
    drive(0, 0, 32'h0400_0060, BR_BGTZ, 32'hFFFF_FFFB, 3);
    drive(0, 0, 32'h0400_0070, BR_BLEZ, 32'hFFFF_FFFB, 3);
    drive(0, 0, 32'h0400_0080, BR_BLTZ, 32'hFFFF_FFFB, 3);
    // BNE held under stall with toggling flags, then released.
    drive(0, 1, 32'h1400_0100, BR_BNE, 5, 6);
    drive(0, 1, 32'h1400_0200, BR_BNE, 5, 5);
    drive(0, 1, 32'h1400_0300, BR_BNE, 9, 6);
    drive(0, 0, 32'h1400_0400, BR_BNE, 5, 6);
    drive(1, 1, 32'h1400_0500, BR_BNE, 5, 6);     // reset beats stall
    // J and JR, JR to the top of memory to exercise the wrap.
    drive(0, 0, 32'h0800_0C10, BR_NONE, 0, 0);
    drive(0, 0, 32'hA000_1000, BR_J, 0, 0);
    drive(0, 0, 32'hA000_2000, BR_JR, 32'h0000_3001, 0);
    drive(0, 0, 32'hA000_3000, BR_NONE, 0, 0);
    drive(0, 0, 32'hA000_4000, BR_BGEZALR, 5, 32'h0000_3100);
    drive(0, 0, 32'hA000_5000, BR_JR, 32'hFFFF_FFFC, 0);
    drive(0, 0, 32'hA000_6000, BR_NONE, 0, 0);
    drive(0, 0, 32'hA000_7000, BR_NONE, 0, 0);
    drive(0, 0, 32'hA000_8000, BR_NONE, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      case ($urandom_range(0, 4))
        0:       rs = 32'd0;
        1:       rs = 32'hFFFF_FFFB;
        2:       rs = 32'($urandom_range(1, 100));
        3:       rs = $urandom;
        default: rs = rt;
      endcase
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom,
            4'($urandom_range(0, 15)), rs, rt);
    end

    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
